// File: rtl/note_hit_judge.sv
// Note hit judgement: turns key presses and frame ticks into per-lane hit/miss events,
// keeps the combo and multiplier, and accumulates a saturating 4-digit BCD score.
module note_hit_judge #(
    parameter int unsigned HIT_LINE_Y  = 400,
    parameter int unsigned GOOD_WIN    = 12,
    parameter int unsigned PERFECT_WIN = 4,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [49:0] lane_y_pos,
    output logic [4:0]  hit_pulse,
    output logic        miss_pulse,
    output logic [1:0]  judge,
    output logic [7:0]  combo,
    output logic [2:0]  multiplier,
    output logic [15:0] score_bcd,
    output logic        busy
);

    localparam logic [10:0] HitY  = 11'(HIT_LINE_Y);
    localparam logic [10:0] PassY = 11'(HIT_LINE_Y + GOOD_WIN);
    localparam logic [10:0] ArmY  = 11'(HIT_LINE_Y - GOOD_WIN);
    localparam logic [10:0] GoodD = 11'(GOOD_WIN);
    localparam logic [10:0] PerfD = 11'(PERFECT_WIN);
    localparam logic [2:0]  MaxMult = 3'(MAX_MULT);

    localparam logic [1:0] JMiss = 2'd1;
    localparam logic [1:0] JGood = 2'd2;
    localparam logic [1:0] JPerf = 2'd3;

    typedef enum logic [1:0] {StIdle, StScan, StAdd, StDone} state_e;

    state_e state_q, state_d;

    logic [4:0]  key_mask, key_mask_q, press_edge;
    logic [2:0]  frame_sync_q;
    logic        frame_edge;
    logic [4:0]  press_pend_q, press_pend_d;
    logic        frame_pend_q, frame_pend_d;
    logic [4:0]  snap_press_q, snap_press_d;
    logic        snap_frame_q, snap_frame_d;
    logic [4:0]  armed_q, armed_d;
    logic [2:0]  lane_q, lane_d;
    logic [1:0]  digit_q, digit_d;
    logic        carry_q, carry_d;
    logic [6:0]  pts_acc_q, pts_acc_d;
    logic [15:0] sum_q, sum_d;
    logic [4:0]  hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic [1:0]  judge_q, judge_d;
    logic [7:0]  combo_q, combo_d;
    logic [2:0]  mult_q, mult_d;
    logic [15:0] score_q, score_d;

    logic [9:0]         cur_y;
    logic [10:0]        cur_y11;
    logic signed [10:0] y_diff;
    logic [10:0]        y_dist;
    logic [4:0]         lane_bit;
    logic               cur_press, cur_armed, armed_now;
    logic [6:0]         mult7, pts_good, pts_perf;
    logic [7:0]         combo_inc;
    logic [11:0]        pts_bcd;
    logic [3:0]         score_dig, pts_dig, dig_new;
    logic [4:0]         dig_sum;
    logic               dig_carry;
    logic [7:0]         combo_div;

    always_comb begin
        key_mask = '0;
        case (keycode)
            8'h04:   key_mask = 5'b00001;
            8'h16:   key_mask = 5'b00010;
            8'h07:   key_mask = 5'b00100;
            8'h09:   key_mask = 5'b01000;
            8'h0A:   key_mask = 5'b10000;
            default: key_mask = '0;
        endcase
    end

    assign press_edge = key_mask & ~key_mask_q;
    assign frame_edge = frame_sync_q[1] & ~frame_sync_q[2];

    always_comb begin
        cur_y = lane_y_pos[9:0];
        case (lane_q)
            3'd1:    cur_y = lane_y_pos[19:10];
            3'd2:    cur_y = lane_y_pos[29:20];
            3'd3:    cur_y = lane_y_pos[39:30];
            3'd4:    cur_y = lane_y_pos[49:40];
            default: cur_y = lane_y_pos[9:0];
        endcase
    end

    assign cur_y11   = {1'b0, cur_y};
    assign y_diff    = $signed(cur_y11) - $signed(HitY);
    assign y_dist    = y_diff[10] ? (~y_diff + 11'd1) : y_diff;
    assign lane_bit  = 5'b00001 << lane_q;
    assign cur_press = |(snap_press_q & lane_bit);
    assign cur_armed = |(armed_q & lane_bit);
    assign mult7     = {4'b0, mult_q};
    assign pts_good  = mult7 << 1;
    assign pts_perf  = pts_good + mult7;
    assign combo_inc = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;

    assign pts_bcd = {4'(pts_acc_q / 7'd100), 4'((pts_acc_q / 7'd10) % 7'd10),
                      4'(pts_acc_q % 7'd10)};
    assign score_dig = 4'(score_q >> {digit_q, 2'b00});
    assign pts_dig   = 4'(pts_bcd >> {digit_q, 2'b00});
    assign dig_sum   = {1'b0, score_dig} + {1'b0, pts_dig} + {4'b0, carry_q};
    assign dig_carry = dig_sum > 5'd9;
    assign dig_new   = dig_carry ? 4'(dig_sum - 5'd10) : dig_sum[3:0];
    assign combo_div = 8'(32'(combo_q) / COMBO_STEP);

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if ((|press_pend_q) || frame_pend_q) state_d = StScan;
            StScan: if (lane_q == 3'd4) state_d = (pts_acc_d != '0) ? StAdd : StDone;
            StAdd:  if (digit_q == 2'd3) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q != StIdle);
        hit_pulse  = hit_pulse_q;
        miss_pulse = miss_pulse_q;
        judge      = judge_q;
        combo      = combo_q;
        multiplier = mult_q;
        score_bcd  = score_q;
    end

    // Datapath next-state
    always_comb begin
        press_pend_d = press_pend_q | press_edge;
        frame_pend_d = frame_pend_q | frame_edge;
        snap_press_d = snap_press_q;
        snap_frame_d = snap_frame_q;
        armed_d      = armed_q;
        armed_now    = cur_armed;
        lane_d       = lane_q;
        digit_d      = digit_q;
        carry_d      = carry_q;
        pts_acc_d    = pts_acc_q;
        sum_d        = sum_q;
        hit_pulse_d  = '0;
        miss_pulse_d = 1'b0;
        judge_d      = judge_q;
        combo_d      = combo_q;
        mult_d       = mult_q;
        score_d      = score_q;
        case (state_q)
            StIdle: begin
                if ((|press_pend_q) || frame_pend_q) begin
                    // Edges landing this cycle start the new pend value
                    snap_press_d = press_pend_q;
                    snap_frame_d = frame_pend_q;
                    press_pend_d = press_edge;
                    frame_pend_d = frame_edge;
                    lane_d       = '0;
                    pts_acc_d    = '0;
                end
            end
            StScan: begin
                if (cur_press) begin
                    if (cur_armed && (y_dist <= PerfD)) begin
                        hit_pulse_d = lane_bit;
                        judge_d     = JPerf;
                        pts_acc_d   = pts_acc_q + pts_perf;
                        combo_d     = combo_inc;
                        armed_d     = armed_q & ~lane_bit;
                        armed_now   = 1'b0;
                    end else if (cur_armed && (y_dist <= GoodD)) begin
                        hit_pulse_d = lane_bit;
                        judge_d     = JGood;
                        pts_acc_d   = pts_acc_q + pts_good;
                        combo_d     = combo_inc;
                        armed_d     = armed_q & ~lane_bit;
                        armed_now   = 1'b0;
                    end else begin
                        miss_pulse_d = 1'b1;
                        judge_d      = JMiss;
                        combo_d      = '0;
                    end
                end
                if (snap_frame_q) begin
                    if (armed_now && (cur_y11 > PassY)) begin
                        miss_pulse_d = 1'b1;
                        judge_d      = JMiss;
                        combo_d      = '0;
                        armed_d      = armed_d & ~lane_bit;
                    end else if (!cur_armed && (cur_y11 < ArmY)) begin
                        armed_d = armed_d | lane_bit;
                    end
                end
                lane_d  = lane_q + 3'd1;
                digit_d = '0;
                carry_d = 1'b0;
            end
            StAdd: begin
                case (digit_q)
                    2'd0:    sum_d[3:0]   = dig_new;
                    2'd1:    sum_d[7:4]   = dig_new;
                    2'd2:    sum_d[11:8]  = dig_new;
                    default: sum_d[15:12] = dig_new;
                endcase
                carry_d = dig_carry;
                digit_d = digit_q + 2'd1;
                if (digit_q == 2'd3) score_d = dig_carry ? 16'h9999 : {dig_new, sum_q[11:0]};
            end
            StDone: begin
                mult_d = (combo_div >= 8'(MAX_MULT)) ? MaxMult : 3'(combo_div) + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_mask_q   <= '0;
            frame_sync_q <= '0;
            press_pend_q <= '0;
            frame_pend_q <= 1'b0;
            snap_press_q <= '0;
            snap_frame_q <= 1'b0;
            armed_q      <= '1;
            lane_q       <= '0;
            digit_q      <= '0;
            carry_q      <= 1'b0;
            pts_acc_q    <= '0;
            sum_q        <= '0;
            hit_pulse_q  <= '0;
            miss_pulse_q <= 1'b0;
            judge_q      <= '0;
            combo_q      <= '0;
            mult_q       <= 3'd1;
            score_q      <= '0;
        end else begin
            key_mask_q   <= key_mask;
            frame_sync_q <= {frame_sync_q[1:0], frame_clk};
            press_pend_q <= press_pend_d;
            frame_pend_q <= frame_pend_d;
            snap_press_q <= snap_press_d;
            snap_frame_q <= snap_frame_d;
            armed_q      <= armed_d;
            lane_q       <= lane_d;
            digit_q      <= digit_d;
            carry_q      <= carry_d;
            pts_acc_q    <= pts_acc_d;
            sum_q        <= sum_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            judge_q      <= judge_d;
            combo_q      <= combo_d;
            mult_q       <= mult_d;
            score_q      <= score_d;
        end
    end

endmodule

// File: tb/tb_note_hit_judge.sv
// Directed bench for note_hit_judge: table of press/frame vectors, a long perfect-hit
// streak against a small score/combo model, and a reset-during-scan sequence.
module tb_note_hit_judge;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = '0;
    logic [49:0] lane_y_pos = '0;
    logic [4:0]  hit_pulse;
    logic        miss_pulse;
    logic [1:0]  judge;
    logic [7:0]  combo;
    logic [2:0]  multiplier;
    logic [15:0] score_bcd;
    logic        busy;

    note_hit_judge dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .lane_y_pos (lane_y_pos),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .judge      (judge),
        .combo      (combo),
        .multiplier (multiplier),
        .score_bcd  (score_bcd),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled away from the active edge
    int         hit_cnt = 0;
    int         miss_cnt = 0;
    logic [4:0] last_hit = '0;
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (|hit_pulse) begin
                hit_cnt  += $countones(hit_pulse);
                last_hit = hit_pulse;
            end
            if (miss_pulse) miss_cnt++;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rearm;
        logic        frame;
        logic [7:0]  key;
        int          lane;
        int          y;
        int          hold;
        logic [4:0]  exp_hit;
        int          exp_miss;
        int          exp_judge;
        int          exp_combo;
        int          exp_mult;
        logic [15:0] exp_score;
        logic        scan;
    } vec_t;

    localparam int NumVec = 15;
    vec_t       vecs [NumVec];
    logic [7:0] keymap [5] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0A};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic level, input int budget, input string name);
        int k = 0;
        while (busy !== level && k < budget) begin
            @(negedge Clk);
            k++;
        end
        check(name, {31'b0, busy}, {31'b0, level});
    endtask

    task automatic set_lane(input int lane, input int y);
        lane_y_pos = '0;
        lane_y_pos[lane*10 +: 10] = 10'(y);
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        wait_busy(1'b1, 12, "frame_start");
        frame_clk = 1'b0;
        wait_busy(1'b0, 30, "frame_done");
        repeat (2) @(negedge Clk);
    endtask

    task automatic rearm_all();
        lane_y_pos = '0;
        frame_tick();
    endtask

    task automatic press(input logic [7:0] key, input int hold, input logic scan);
        keycode = key;
        if (scan) begin
            wait_busy(1'b1, 12, "press_start");
            wait_busy(1'b0, 30, "press_done");
        end else begin
            repeat (20) @(negedge Clk);
        end
        repeat (hold) @(negedge Clk);
        keycode = '0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic check_state(input string tag, input int j, input int c, input int m,
                               input logic [15:0] s);
        check({tag, ".judge"}, 32'(judge), 32'(j));
        check({tag, ".combo"}, 32'(combo), 32'(c));
        check({tag, ".mult"}, 32'(multiplier), 32'(m));
        check({tag, ".score"}, 32'(score_bcd), 32'(s));
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        int h0, m0;
        int m_score, m_combo, m_mult, n;
        bit saturated;

        // rearm frame key lane y hold hit miss judge combo mult score scan
        vecs[0]  = '{1'b0, 1'b0, 8'h04, 0, 402, 1000, 5'b00001, 0, 3, 1, 1, 16'h0003, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'h07, 2, 410, 0, 5'b00100, 0, 2, 2, 1, 16'h0005, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h07, 2, 300, 0, 5'b00000, 1, 1, 0, 1, 16'h0005, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h00, 4, 405, 0, 5'b00000, 0, 1, 0, 1, 16'h0005, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 4, 409, 0, 5'b00000, 0, 1, 0, 1, 16'h0005, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 4, 412, 0, 5'b00000, 0, 1, 0, 1, 16'h0005, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 4, 415, 0, 5'b00000, 1, 1, 0, 1, 16'h0005, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 4, 0, 0, 5'b00000, 0, 1, 0, 1, 16'h0005, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 4, 380, 0, 5'b00000, 0, 1, 0, 1, 16'h0005, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h0A, 4, 400, 0, 5'b10000, 0, 3, 1, 1, 16'h0008, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h09, 3, 388, 0, 5'b01000, 0, 2, 2, 1, 16'h0010, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 8'h16, 1, 413, 0, 5'b00000, 1, 1, 0, 1, 16'h0010, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 8'h04, 0, 396, 0, 5'b00001, 0, 3, 1, 1, 16'h0013, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'h04, 0, 400, 0, 5'b00000, 1, 1, 0, 1, 16'h0013, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 8'h05, 0, 400, 0, 5'b00000, 0, 1, 0, 1, 16'h0013, 1'b0};

        // Reset state and quiet idle
        repeat (3) @(negedge Clk);
        check_state("reset", 0, 0, 1, 16'h0000);
        check("reset.busy", {31'b0, busy}, 32'd0);
        Reset_n = 1'b1;
        repeat (100) @(negedge Clk);
        check("idle.hits", 32'(hit_cnt), 32'd0);
        check("idle.misses", 32'(miss_cnt), 32'd0);

        for (int i = 0; i < NumVec; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].rearm) rearm_all();
            h0 = hit_cnt;
            m0 = miss_cnt;
            set_lane(vecs[i].lane, vecs[i].y);
            if (vecs[i].frame) frame_tick();
            else press(vecs[i].key, vecs[i].hold, vecs[i].scan);
            check({tag, ".hits"}, 32'(hit_cnt - h0), 32'($countones(vecs[i].exp_hit)));
            if (vecs[i].exp_hit != '0) check({tag, ".lane"}, 32'(last_hit), 32'(vecs[i].exp_hit));
            check({tag, ".misses"}, 32'(miss_cnt - m0), 32'(vecs[i].exp_miss));
            check_state(tag, vecs[i].exp_judge, vecs[i].exp_combo, vecs[i].exp_mult,
                        vecs[i].exp_score);
        end

        // Perfect streak up to score saturation
        m_score = 13;
        m_combo = 0;
        m_mult = 1;
        n = 0;
        saturated = 1'b0;
        while (!saturated && n < 1200) begin
            int lane;
            lane = n % 5;
            rearm_all();
            h0 = hit_cnt;
            set_lane(lane, 400);
            press(keymap[lane], 0, 1'b1);
            if (m_score == 9999) saturated = 1'b1;
            m_score = (m_score + 3 * m_mult > 9999) ? 9999 : m_score + 3 * m_mult;
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
            m_mult = (1 + m_combo / 10 > 4) ? 4 : 1 + m_combo / 10;
            check("streak.hits", 32'(hit_cnt - h0), 32'd1);
            check("streak.lane", 32'(last_hit), 32'(5'b00001 << lane));
            check_state("streak", 3, m_combo, m_mult, to_bcd(m_score));
            if (n == 9) check("streak.mult_at_10", 32'(multiplier), 32'd2);
            if (n == 10) check("streak.score_11th", 32'(score_bcd), 32'h0049);
            if (n == 39) check("streak.mult_at_40", 32'(multiplier), 32'd4);
            if (m_score == 9999 && !saturated && n > 100) begin
                check("streak.saturate", 32'(score_bcd), 32'h9999);
            end
            n++;
        end
        check("streak.reached_9999", {31'b0, saturated}, 32'd1);
        check("streak.combo_sat", 32'(combo), 32'd255);

        // Reset while the FSM is scanning
        rearm_all();
        set_lane(0, 400);
        keycode = 8'h04;
        wait_busy(1'b1, 12, "rst_scan_start");
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_state("midreset", 0, 0, 1, 16'h0000);
        check("midreset.busy", {31'b0, busy}, 32'd0);
        check("midreset.hit", 32'(hit_pulse), 32'd0);
        check("midreset.miss", {31'b0, miss_pulse}, 32'd0);
        keycode = '0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        h0 = hit_cnt;
        m0 = miss_cnt;
        repeat (30) @(negedge Clk);
        check("postreset.hits", 32'(hit_cnt - h0), 32'd0);
        check("postreset.misses", 32'(miss_cnt - m0), 32'd0);
        check("postreset.score", 32'(score_bcd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
